// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the load-store port and the shared memory bus of mem_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;

  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [DATA_W/8-1:0]   ls_be_i;
  logic [ADDR_W-1:0]     ls_addr_i;
  logic [DATA_W-1:0]     ls_wdata_i;
  logic                  ls_gnt_o;
  logic                  ls_rvalid_o;
  logic [DATA_W-1:0]     ls_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_W/8-1:0]   mem_be_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load-store,
// with a single outstanding transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {PORT_IF = 1'b0, PORT_LS = 1'b1} port_t;

  state_t            state_q, state_d;
  port_t             owner_q, last_grant_q, sel;
  logic              any_req, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              sel_we;

  assign any_req = bus.if_req_i | bus.ls_req_i;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    sel = PORT_IF;
    if (bus.ls_req_i && (!bus.if_req_i || last_grant_q == PORT_IF)) begin
      sel = PORT_LS;
    end
  end

  always_comb begin
    sel_addr  = bus.if_addr_i;
    sel_we    = 1'b0;
    sel_be    = '1;
    sel_wdata = '0;
    if (sel == PORT_LS) begin
      sel_addr  = bus.ls_addr_i;
      sel_we    = bus.ls_we_i;
      sel_be    = bus.ls_be_i;
      sel_wdata = bus.ls_wdata_i;
    end
  end

  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_we_o    = sel_we;
  assign bus.mem_be_o    = sel_be;
  assign bus.mem_wdata_o = sel_wdata;
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.ls_rdata_o  = bus.mem_rdata_i;

  // Handshake outputs are held off while reset is asserted so nothing is granted mid-reset.
  always_comb begin
    state_d         = state_q;
    grant           = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.if_gnt_o    = 1'b0;
    bus.ls_gnt_o    = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.ls_rvalid_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus.mem_req_o = any_req && !rst_i;
        if (any_req && bus.mem_gnt_i && !rst_i) begin
          grant        = 1'b1;
          bus.if_gnt_o = (sel == PORT_IF);
          bus.ls_gnt_o = (sel == PORT_LS);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i && !rst_i) begin
          bus.if_rvalid_o = (owner_q == PORT_IF);
          bus.ls_rvalid_o = (owner_q == PORT_LS);
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= PORT_IF;
      last_grant_q <= PORT_LS;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= sel;
        last_grant_q <= sel;
      end
    end
  end
endmodule
